sc_refill_arbiter: RTL

//  Shares one AXI4 read master between the I-cache and D-cache miss paths of the
//  n-way simple cache. Each miss is one line refill, issued as an INCR burst to
//  the instruction or data memory. Returned beats are streamed back to the

---
 rtl/sc_refill_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sc_refill_arbiter.sv
// sc_refill_arbiter: shares one AXI4 read master between I-cache and D-cache line refills
// Ports: clk, rst (async, active-high); i_*/d_* request side (req/addr in, gnt pulse out)
// and return side (rvalid/rlast/rerr out); rdata_o shared beat data; m_axi_ar* / m_axi_r*
// AXI4 read address and data channels; busy_o high whenever a refill is in flight.
module sc_refill_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_gnt_o,
    output logic                  i_rvalid_o,
    output logic                  i_rlast_o,
    output logic                  i_rerr_o,
    input  logic                  d_req_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic                  d_rlast_o,
    output logic                  d_rerr_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  busy_o
);
    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * DATA_WIDTH / 8 - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rr_q, rr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  gnt_q, gnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  rerr_q, rerr_d;
    logic                  pick, cnt_end, beat;

    // owner / rr encoding: 0 = I-cache, 1 = D-cache
    assign pick    = (i_req_i & d_req_i) ? rr_q : d_req_i;
    assign cnt_end = cnt_q == CW'(LINE_WORDS - 1);
    assign beat    = m_axi_rvalid & rready_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        gnt_d     = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        rerr_d    = 1'b0;
        case (state_q)
            IDLE: if (i_req_i | d_req_i) begin
                state_d   = ADDR;
                owner_d   = pick;
                gnt_d     = 1'b1;
                arvalid_d = 1'b1;
                araddr_d  = (pick ? d_addr_i : i_addr_i) & ~LINE_MASK;
            end
            ADDR: if (m_axi_arready) begin
                state_d   = DATA;
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            DATA: if (beat) begin
                rvalid_d = 1'b1;
                rdata_d  = m_axi_rdata;
                cnt_d    = cnt_q + CW'(1);
                // an early rlast terminates the burst; a missing one is flagged but still ends it
                rlast_d  = cnt_end | m_axi_rlast;
                rerr_d   = (m_axi_rresp != 2'b00) | (m_axi_rlast != cnt_end);
                if (cnt_end | m_axi_rlast) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    rready_d = 1'b0;
                    rr_d     = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            gnt_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rerr_q    <= rerr_d;
        end
    end

    // owner_q only changes on a grant edge, which also clears the previous beat flags
    assign i_gnt_o       = gnt_q & ~owner_q;
    assign d_gnt_o       = gnt_q & owner_q;
    assign i_rvalid_o    = rvalid_q & ~owner_q;
    assign d_rvalid_o    = rvalid_q & owner_q;
    assign i_rlast_o     = rlast_q & ~owner_q;
    assign d_rlast_o     = rlast_q & owner_q;
    assign i_rerr_o      = rerr_q & ~owner_q;
    assign d_rerr_o      = rerr_q & owner_q;
    assign rdata_o       = rdata_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign busy_o        = state_q != IDLE;
endmodule
